// File: rtl/instr_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_if
// Request handshake and instruction-memory write bus for instr_encoder_loader.
//   req_valid / req_ready      : request handshake (producer -> loader)
//   req_class, req_op          : instruction class and per-class operation code
//   req_rd, req_rs1, req_rs2   : register fields
//   req_imm                    : sign-extended immediate / byte offset
//   imem_we, imem_addr, imem_wdata : instruction-memory write port (loader -> memory)
// The master modport is the request producer; the slave modport is the loader.
// -----------------------------------------------------------------------------
interface instr_encoder_loader_if #(
   parameter int AW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_class;
   logic [3:0]    req_op;
   logic [4:0]    req_rd;
   logic [4:0]    req_rs1;
   logic [4:0]    req_rs2;
   logic [31:0]   req_imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   modport master (
      output req_valid, req_class, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, req_class, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Packs one decoded instruction description per handshake into an RV32I word
// and writes it to consecutive instruction-memory words starting at BASE.
// Loading finishes after a SYSTEM instruction is written or when the last
// memory word has been written (overflow, flagged in err).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle pulse, arms the loader and clears pointer/count/flags
//   bus        : request handshake + instruction-memory write port (slave)
//   done       : load finished, held until the next start
//   err        : sticky error (illegal request or overflow)
//   count      : words written since start
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int AW   = 8,
   parameter int BASE = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   instr_encoder_loader_if.slave       bus,
   output logic                        done,
   output logic                        err,
   output logic [AW:0]                 count
);
   localparam logic [AW-1:0] L_BASE = AW'(BASE);

   localparam logic [3:0] CLS_ALUREG = 4'd0;
   localparam logic [3:0] CLS_ALUIMM = 4'd1;
   localparam logic [3:0] CLS_LOAD   = 4'd2;
   localparam logic [3:0] CLS_STORE  = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_JAL    = 4'd5;
   localparam logic [3:0] CLS_JALR   = 4'd6;
   localparam logic [3:0] CLS_LUI    = 4'd7;
   localparam logic [3:0] CLS_AUIPC  = 4'd8;
   localparam logic [3:0] CLS_SYSTEM = 4'd9;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_DONE} state_e;

   state_e        r_state;
   logic [AW-1:0] r_ptr;
   logic [AW:0]   r_count;
   logic          r_req_ready;
   logic          r_imem_we;
   logic [AW-1:0] r_imem_addr;
   logic [31:0]   r_imem_wdata;
   logic          r_done;
   logic          r_err;
   logic          r_is_sys;

   logic [2:0]    w_alu_f3;
   logic          w_alu_alt;
   logic          w_alu_ok;
   logic [2:0]    w_f3;
   logic          w_legal;
   logic [31:0]   w_word;

   // Internal alu_control code -> funct3; alt selects funct7=0100000 (sub/sra).
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_alu_ok  = 1'b1;
      w_alu_f3  = 3'b000;
      w_alu_alt = 1'b0;
      case (bus.req_op)
         4'b0010: w_alu_f3 = 3'b000;                      // add
         4'b0101: begin w_alu_f3 = 3'b000; w_alu_alt = 1'b1; end // sub
         4'b0011: w_alu_f3 = 3'b001;                      // sll
         4'b0110: w_alu_f3 = 3'b010;                      // slt
         4'b0111: w_alu_f3 = 3'b011;                      // sltu
         4'b0100: w_alu_f3 = 3'b100;                      // xor
         4'b1000: w_alu_f3 = 3'b101;                      // srl
         4'b1001: begin w_alu_f3 = 3'b101; w_alu_alt = 1'b1; end // sra
         4'b0001: w_alu_f3 = 3'b110;                      // or
         4'b0000: w_alu_f3 = 3'b111;                      // and
         default: w_alu_ok = 1'b0;
      endcase
   end

   // Field packing for the request currently on the bus.
   always_comb begin
      w_legal = 1'b1;
      w_f3    = 3'b000;
      w_word  = 32'h0000_0000;
      case (bus.req_class)
         CLS_ALUREG: begin
            w_legal = w_alu_ok;
            w_word  = {1'b0, w_alu_alt, 5'b0, bus.req_rs2, bus.req_rs1, w_alu_f3,
                       bus.req_rd, 7'b0110011};
         end
         CLS_ALUIMM: begin
            w_legal = w_alu_ok && (bus.req_op != 4'b0101);
            // Shifts carry only a 5-bit shamt; the upper immediate bits become funct7.
            if (w_alu_f3 == 3'b001 || w_alu_f3 == 3'b101)
               w_word = {1'b0, w_alu_alt, 5'b0, bus.req_imm[4:0], bus.req_rs1, w_alu_f3,
                         bus.req_rd, 7'b0010011};
            else
               w_word = {bus.req_imm[11:0], bus.req_rs1, w_alu_f3, bus.req_rd, 7'b0010011};
         end
         CLS_LOAD: begin
            case (bus.req_op)
               4'b0010: w_f3 = 3'b000;   // lb
               4'b0100: w_f3 = 3'b001;   // lh
               4'b0101: w_f3 = 3'b010;   // lw
               4'b0000: w_f3 = 3'b100;   // lbu
               4'b0001: w_f3 = 3'b101;   // lhu
               default: w_legal = 1'b0;
            endcase
            w_word = {bus.req_imm[11:0], bus.req_rs1, w_f3, bus.req_rd, 7'b0000011};
         end
         CLS_STORE: begin
            if (bus.req_op <= 4'b0010) w_f3 = bus.req_op[2:0];
            else                       w_legal = 1'b0;
            w_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, w_f3,
                      bus.req_imm[4:0], 7'b0100011};
         end
         CLS_BRANCH: begin
            case (bus.req_op)
               4'b0000: w_f3 = 3'b000;   // beq
               4'b0001: w_f3 = 3'b001;   // bne
               4'b0011: w_f3 = 3'b100;   // blt
               4'b0010: w_f3 = 3'b101;   // bge
               4'b0100: w_f3 = 3'b110;   // bltu
               4'b0101: w_f3 = 3'b111;   // bgeu
               default: w_legal = 1'b0;
            endcase
            // Branch targets are halfword aligned; an odd offset cannot be encoded.
            if (bus.req_imm[0]) w_legal = 1'b0;
            w_word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, w_f3,
                      bus.req_imm[4:1], bus.req_imm[11], 7'b1100011};
         end
         CLS_JAL: begin
            w_legal = ~bus.req_imm[0];
            w_word  = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                       bus.req_imm[19:12], bus.req_rd, 7'b1101111};
         end
         CLS_JALR:   w_word = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, 7'b1100111};
         CLS_LUI:    w_word = {bus.req_imm[31:12], bus.req_rd, 7'b0110111};
         CLS_AUIPC:  w_word = {bus.req_imm[31:12], bus.req_rd, 7'b0010111};
         CLS_SYSTEM: w_word = 32'h0000_0073;
         default:    w_legal = 1'b0;
      endcase
   end

   // Loader FSM with all outputs registered.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= L_BASE;
         r_count      <= '0;
         r_req_ready  <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= L_BASE;
         r_imem_wdata <= 32'h0000_0000;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_is_sys     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state     <= ST_ACCEPT;
                  r_req_ready <= 1'b1;
                  r_ptr       <= L_BASE;
                  r_count     <= '0;
                  r_done      <= 1'b0;
                  r_err       <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               // start takes priority: a request presented in the same cycle stays pending.
               if (start) begin
                  r_ptr   <= L_BASE;
                  r_count <= '0;
                  r_err   <= 1'b0;
               end else if (bus.req_valid) begin
                  if (w_legal) begin
                     r_state      <= ST_WRITE;
                     r_req_ready  <= 1'b0;
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_ptr;
                     r_imem_wdata <= w_word;
                     r_is_sys     <= (bus.req_class == CLS_SYSTEM);
                  end else begin
                     r_err <= 1'b1;        // illegal request is consumed without a write
                  end
               end
            end
            ST_WRITE: begin
               r_imem_we <= 1'b0;
               r_ptr     <= r_ptr + 1'b1;
               r_count   <= r_count + 1'b1;
               if (r_is_sys) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (&r_ptr) begin
                  r_state <= ST_DONE;      // last word written without SYSTEM: overflow
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  r_state     <= ST_ACCEPT;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.imem_we    = r_imem_we;
   assign bus.imem_addr  = r_imem_addr;
   assign bus.imem_wdata = r_imem_wdata;
   assign done           = r_done;
   assign err            = r_err;
   assign count          = r_count;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Bench for instr_encoder_loader: a directed vector table with hand-computed
// RV32I words, randomized requests against a mnemonic-level reference encoder,
// and hand-written sequences for start/valid collision, overflow (AW=2 copy)
// and reset during a write cycle.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;
   localparam int AW      = 8;
   localparam int DEPTH   = 1 << AW;
   localparam int AW_S    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done, err, done_s, err_s;
   logic [AW:0]   count;
   logic [AW_S:0] count_s;

   instr_encoder_loader_if #(.AW(AW))   if_a ();
   instr_encoder_loader_if #(.AW(AW_S)) if_s ();

   instr_encoder_loader #(.AW(AW), .BASE(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(if_a.slave),
      .done(done), .err(err), .count(count)
   );

   instr_encoder_loader #(.AW(AW_S), .BASE(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(if_s.slave),
      .done(done_s), .err(err_s), .count(count_s)
   );

   // The small copy sees the same request stream as the main one.
   assign if_s.req_valid = if_a.req_valid;
   assign if_s.req_class = if_a.req_class;
   assign if_s.req_op    = if_a.req_op;
   assign if_s.req_rd    = if_a.req_rd;
   assign if_s.req_rs1   = if_a.req_rs1;
   assign if_s.req_rs2   = if_a.req_rs2;
   assign if_s.req_imm   = if_a.req_imm;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected loader state, tracked at transaction level.
   int m_ptr = 0;
   int m_count = 0;
   bit m_err = 1'b0;
   bit m_done = 1'b0;

   int small_addrs[$];
   always @(negedge clk) if (if_s.imem_we) small_addrs.push_back(int'(if_s.imem_addr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference encoder (mnemonic level) ----------------
   function automatic string mnemonic(input int cls, input int op);
      string n = "";
      case (cls)
         0, 1: case (op)
                  2: n = "add";  5: n = "sub";  6: n = "slt"; 7: n = "sltu"; 4: n = "xor";
                  8: n = "srl";  1: n = "or";   0: n = "and"; 3: n = "sll";  9: n = "sra";
                  default: n = "";
               endcase
         2: case (op) 2: n = "lb"; 4: n = "lh"; 5: n = "lw"; 0: n = "lbu"; 1: n = "lhu";
                      default: n = ""; endcase
         3: case (op) 0: n = "sb"; 1: n = "sh"; 2: n = "sw"; default: n = ""; endcase
         4: case (op) 0: n = "beq"; 1: n = "bne"; 3: n = "blt"; 2: n = "bge";
                      4: n = "bltu"; 5: n = "bgeu"; default: n = ""; endcase
         default: n = "";
      endcase
      return n;
   endfunction

   function automatic logic [31:0] funct3(input string n);
      case (n)
         "add", "sub", "lb", "sb", "beq":  return 0;
         "sll", "lh", "sh", "bne":         return 1;
         "slt", "lw", "sw":                return 2;
         "sltu":                           return 3;
         "xor", "lbu", "blt":              return 4;
         "srl", "sra", "lhu", "bge":       return 5;
         "or", "bltu":                     return 6;
         "and", "bgeu":                    return 7;
         default:                          return 0;
      endcase
   endfunction

   function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
      return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   function automatic void ref_encode(input int cls, input int op, input logic [31:0] rd,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [31:0] imm, output bit legal,
                                      output logic [31:0] word);
      string n = mnemonic(cls, op);
      logic [31:0] f3 = funct3(n);
      logic [31:0] i12;
      legal = 1'b1;
      word  = 0;
      case (cls)
         0: begin
            legal = (n != "");
            word = (((n == "sub") || (n == "sra")) ? 32'h20 : 0) << 25 | rs2 << 20 | rs1 << 15
                   | f3 << 12 | rd << 7 | 32'h33;
         end
         1: begin
            legal = (n != "") && (n != "sub");
            if (n == "sll" || n == "srl" || n == "sra")
               i12 = ((n == "sra") ? 32'h400 : 0) + bits(imm, 4, 0);
            else
               i12 = bits(imm, 11, 0);
            word = i12 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h13;
         end
         2: begin
            legal = (n != "");
            word = bits(imm, 11, 0) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h03;
         end
         3: begin
            legal = (n != "");
            word = bits(imm, 11, 5) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
                   | bits(imm, 4, 0) << 7 | 32'h23;
         end
         4: begin
            legal = (n != "") && (imm % 2 == 0);
            word = bits(imm, 12, 12) << 31 | bits(imm, 10, 5) << 25 | rs2 << 20 | rs1 << 15
                   | f3 << 12 | bits(imm, 4, 1) << 8 | bits(imm, 11, 11) << 7 | 32'h63;
         end
         5: begin
            legal = (imm % 2 == 0);
            word = bits(imm, 20, 20) << 31 | bits(imm, 10, 1) << 21 | bits(imm, 11, 11) << 20
                   | bits(imm, 19, 12) << 12 | rd << 7 | 32'h6F;
         end
         6: word = bits(imm, 11, 0) << 20 | rs1 << 15 | rd << 7 | 32'h67;
         7: word = bits(imm, 31, 12) << 12 | rd << 7 | 32'h37;
         8: word = bits(imm, 31, 12) << 12 | rd << 7 | 32'h17;
         9: word = 32'h73;
         default: legal = 1'b0;
      endcase
   endfunction

   // ---------------- stimulus tasks ----------------
   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
      check("ready_after_start", if_a.req_ready, 1);
      check("count_after_start", count, 0);
      check("done_after_start", done, 0);
   endtask

   // Present one request, wait (bounded) for ready, then check the write cycle
   // and the cycle after it against the expected word and loader state.
   task automatic do_req(input logic [3:0] cls, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input bit legal, input logic [31:0] exp_word);
      int n = 0;
      if_a.req_class = cls; if_a.req_op = op; if_a.req_rd = rd;
      if_a.req_rs1 = rs1; if_a.req_rs2 = rs2; if_a.req_imm = imm;
      if_a.req_valid = 1'b1;
      while (!if_a.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!if_a.req_ready) begin
         check("ready_timeout", if_a.req_ready, 1);
         if_a.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      if_a.req_valid = 1'b0;
      if (legal) begin
         check("we_in_write", if_a.imem_we, 1);
         check("addr", if_a.imem_addr, m_ptr);
         check("wdata", if_a.imem_wdata, exp_word);
         check("ready_in_write", if_a.req_ready, 0);
         @(negedge clk);
         m_count++;
         if (cls == 4'd9) m_done = 1'b1;
         else if (m_ptr == DEPTH - 1) begin m_done = 1'b1; m_err = 1'b1; end
         m_ptr = (m_ptr + 1) % DEPTH;
         check("we_one_cycle", if_a.imem_we, 0);
         check("count", count, m_count);
         check("done", done, m_done);
         check("err", err, m_err);
         check("ready_after_write", if_a.req_ready, !m_done);
      end else begin
         m_err = 1'b1;
         check("we_illegal", if_a.imem_we, 0);
         check("err_illegal", err, 1);
         check("ready_illegal", if_a.req_ready, 1);
         check("count_illegal", count, m_count);
      end
   endtask

   typedef struct {
      logic [3:0]  cls;
      logic [3:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      bit          legal;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [3:0]  r_cls, r_op;
      logic [4:0]  r_rd, r_rs1, r_rs2;
      logic [31:0] r_imm;
      bit          e_legal;
      logic [31:0] e_word;

      if_a.req_valid = 1'b0; if_a.req_class = '0; if_a.req_op = '0;
      if_a.req_rd = '0; if_a.req_rs1 = '0; if_a.req_rs2 = '0; if_a.req_imm = '0;

      vecs.push_back('{4'd0, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd0,  1'b1, 32'h003100B3}); // add
      vecs.push_back('{4'd0, 4'b0101, 5'd5, 5'd6, 5'd7, 32'd0,  1'b1, 32'h407302B3}); // sub
      vecs.push_back('{4'd1, 4'b0010, 5'd1, 5'd0, 5'd0, -32'sd1, 1'b1, 32'hFFF00093}); // addi -1
      vecs.push_back('{4'd1, 4'b0101, 5'd1, 5'd2, 5'd0, 32'd3,  1'b0, 32'h0});         // subi
      vecs.push_back('{4'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8,  1'b1, 32'h00208463}); // beq
      vecs.push_back('{4'd5, 4'b0000, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b1, 32'hFFDFF06F}); // jal -4
      vecs.push_back('{4'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd5,  1'b0, 32'h0});         // odd branch
      vecs.push_back('{4'd2, 4'b0101, 5'd1, 5'd2, 5'd0, 32'd4,  1'b1, 32'h00412083}); // lw
      vecs.push_back('{4'd3, 4'b0010, 5'd0, 5'd2, 5'd1, 32'd4,  1'b1, 32'h00112223}); // sw
      vecs.push_back('{4'd1, 4'b1001, 5'd3, 5'd4, 5'd0, 32'hFFF, 1'b1, 32'h41F25193}); // srai 31
      vecs.push_back('{4'd12, 4'b0000, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0});         // bad class
      vecs.push_back('{4'd9, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0,  1'b1, 32'h00000073}); // SYSTEM

      // Reset values.
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", if_a.req_ready, 0);
      check("rst_we", if_a.imem_we, 0);
      check("rst_addr", if_a.imem_addr, 0);
      check("rst_wdata", if_a.imem_wdata, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_count", count, 0);

      // Directed table, ending with SYSTEM.
      do_start();
      foreach (vecs[i])
         do_req(vecs[i].cls, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].imm, vecs[i].legal, vecs[i].word);
      check("done_after_system", done, 1);

      // Restart writes from BASE again.
      do_start();
      do_req(4'd7, 4'd0, 5'd10, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345537);   // lui

      // start and valid together: start wins, request not consumed, err cleared.
      do_req(4'd0, 4'b1111, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
      if_a.req_class = 4'd0; if_a.req_op = 4'b0010; if_a.req_valid = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if_a.req_valid = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
      check("collide_we", if_a.imem_we, 0);
      check("collide_err", err, 0);
      check("collide_count", count, 0);
      check("collide_ready", if_a.req_ready, 1);

      // Randomized requests against the reference encoder.
      for (int k = 0; k < 80; k++) begin
         r_cls = 4'($urandom_range(0, 11));
         r_op  = 4'($urandom_range(0, 15));
         r_rd  = 5'($urandom); r_rs1 = 5'($urandom); r_rs2 = 5'($urandom);
         r_imm = $urandom;
         if ($urandom_range(0, 3) != 0) r_imm[0] = 1'b0;
         ref_encode(int'(r_cls), int'(r_op), 32'(r_rd), 32'(r_rs1), 32'(r_rs2), r_imm,
                    e_legal, e_word);
         do_req(r_cls, r_op, r_rd, r_rs1, r_rs2, r_imm, e_legal, e_word);
         if (m_done) do_start();
      end

      // Overflow on the AW=2 copy: four adds fill the memory.
      do_start();
      small_addrs.delete();
      for (int k = 0; k < 4; k++)
         do_req(4'd0, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h003100B3);
      check("ovf_writes", small_addrs.size(), 4);
      foreach (small_addrs[i]) check("ovf_addr", small_addrs[i], i);
      check("ovf_done", done_s, 1);
      check("ovf_err", err_s, 1);
      check("ovf_count", count_s, 4);
      check("ovf_ready", if_s.req_ready, 0);

      // Reset asserted during a WRITE cycle.
      if_a.req_class = 4'd0; if_a.req_op = 4'b0010; if_a.req_valid = 1'b1;
      @(posedge clk);
      #1;
      if_a.req_valid = 1'b0;
      check("pre_rst_we", if_a.imem_we, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_we", if_a.imem_we, 0);
      check("async_rst_ready", if_a.req_ready, 0);
      check("async_rst_addr", if_a.imem_addr, 0);
      check("async_rst_wdata", if_a.imem_wdata, 0);
      check("async_rst_count", count, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ready", if_a.req_ready, 0);
      check("idle_we", if_a.imem_we, 0);
      do_start();
      do_req(4'd6, 4'd0, 5'd1, 5'd5, 5'd0, 32'h7FF, 1'b1, 32'h7FF280E7);          // jalr

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Field-level RV32I instruction encoder and sequential instruction-memory writer: the write-side counterpart of the instruction decoder. It accepts one decoded instruction description per handshake, packs it into a 32-bit RV32I word using the same internal operation codes the decoder emits (alu_control, br_sel, dm_sel, store_sel), and writes it to consecutive instruction-memory words. Loading stops when a SYSTEM instruction is written, or on memory overflow. Used to load test programs ahead of the single-cycle core.

## Interface
- AW, 8, instruction-memory word-address width; DEPTH = 2**AW words
- BASE, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: arm loader, ptr=BASE, count=0, clear err/done
- req_valid  in  1  request present
- req_ready  out  1  loader can accept
- req_class  in  4  0 ALUreg, 1 ALUimm, 2 Load, 3 Store, 4 Branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM; others illegal
- req_op  in  4  op code, per class (see Operation)
- req_rd, req_rs1, req_rs2  in  5 each  register fields
- req_imm  in  32  immediate, byte offset, sign-extended value
- imem_we  out  1  write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  load finished (sticky until start)
- err  out  1  sticky error flag
- count  out  AW+1  words written since start

## Operation
- States: IDLE (after reset), ACCEPT, WRITE, DONE.
- IDLE: req_ready=0; start -> ACCEPT.
- ACCEPT: req_ready=1. valid&ready with legal request -> register encoded word, -> WRITE. Illegal request: consumed, err=1, no write, stay ACCEPT. start -> restart (ptr=BASE, count=0, err=0).
- WRITE: imem_we=1, imem_addr=ptr, req_ready=0; start ignored. Next: ptr+1, count+1; if class was SYSTEM -> DONE; else if ptr==DEPTH-1 -> DONE with err=1 (overflow); else -> ACCEPT.
- DONE: done=1, req_ready=0; start -> ACCEPT.
- Op codes. ALUreg: 0010 add, 0101 sub, 0110 slt, 0111 sltu, 0100 xor, 1000 srl, 0001 or, 0000 and, 0011 sll, 1001 sra. ALUimm: same set minus sub. Load: 010 lb, 100 lh, 101 lw, 000 lbu, 001 lhu. Store: 00 sb, 01 sh, 10 sw. Branch: 000 beq, 001 bne, 011 blt, 010 bge, 100 bltu, 101 bgeu. Other classes ignore req_op. Any unlisted code -> illegal.
- Formats. R: funct7=0100000 for sub/sra, else 0. I: imm[11:0]; slli/srli/srai: shamt=imm[4:0], funct7=0100000 for srai, else 0. JALR: I-type, funct3 000. S: imm[11:5] into [31:25], imm[4:0] into [11:7].
- B: imm[12|10:5|4:1|11]. J: imm[20|10:1|11|19:12]. B and J require imm[0]=0, else illegal.
- U (LUI/AUIPC): imm[31:12]. SYSTEM: 0x00000073. Unused immediate bits are truncated silently.

## Timing
- Reset: state IDLE, req_ready=0, imem_we=0, imem_addr=BASE, imem_wdata=0, done=0, err=0, count=0, ptr=BASE.
- Handshake at edge T in ACCEPT -> imem_we high for exactly cycle T+1, with registered data/addr -> req_ready high again at T+2 (unless DONE). Throughput is 1 word per 2 cycles.
- Illegal request at T: err=1 from T+1, req_ready stays 1.
- imem_addr/imem_wdata stable during the whole WRITE cycle; both hold their last value otherwise.
- start and valid in same ACCEPT cycle: start wins, request not consumed.
- rst_n low mid-WRITE: imem_we drops immediately (async), all outputs take reset values.

## Test plan
- start, ALUreg add rd=1 rs1=2 rs2=3 -> imem_we one cycle, addr 0, wdata 0x003100B3, count=1, ready back two cycles after accept.
- ALUreg sub x5,x6,x7 -> 0x407302B3; ALUimm addi x1,x0,imm=-1 -> 0xFFF00093; ALUimm op 0101 -> err=1, no write.
- Branch beq rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=0 imm=-4 -> 0xFFDFF06F; Branch imm=5 -> err=1, no write, ptr unchanged.
- Load lw rd=1 rs1=2 imm=4 -> 0x00412083; Store sw rs1=2 rs2=1 imm=4 -> 0x00112223; SYSTEM -> 0x00000073, then done=1, req_ready=0; new start -> addr restarts at BASE.
- AW=2, four ALUreg adds, no SYSTEM -> writes to addr 0..3, then done=1, err=1, count=4.
- rst_n asserted during WRITE cycle -> imem_we=0 the same cycle, state IDLE, req_ready=0 until start.
